// File: rtl/lsu_dm_master_pkg.sv
// Shared encodings and default address window for the data-memory load/store initiator.
package lsu_dm_master_pkg;

   localparam logic [31:0] DEF_ADDR_LO = 32'h0000_0000;
   localparam logic [31:0] DEF_ADDR_HI = 32'h0000_0FFF;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_RESP = 2'b11
   } state_e;

   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/lsu_dm_master_if.sv
// Request/response bundle from the MEM stage and the word-wide data-memory port.
interface lsu_dm_req_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_sext;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );
   modport slave (
      input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface lsu_dm_mem_if;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic [31:0] mem_pc;

   modport master (
      output mem_we, mem_addr, mem_wd, mem_pc,
      input  mem_rd
   );
   modport slave (
      input  mem_we, mem_addr, mem_wd, mem_pc,
      output mem_rd
   );
endinterface

// File: rtl/lsu_lane_unit.sv
// Combinational little-endian lane merge (stores) and extract + extend (loads); zero latency.
module lsu_lane_unit
   import lsu_dm_master_pkg::*;
(
   input  size_e       i_size,
   input  logic [1:0]  i_lane,
   input  logic        i_sext,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdq,
   output logic [31:0] o_merged,
   output logic [31:0] o_extracted
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      o_merged    = i_rdq;
      o_extracted = '0;
      w_byte      = i_rdq[{i_lane, 3'b000} +: 8];
      w_half      = i_rdq[{i_lane[1], 4'b0000} +: 16];
      case (i_size)
         SZ_B: begin
            o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            o_extracted = {{24{i_sext & w_byte[7]}}, w_byte};
         end
         SZ_H: begin
            o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            o_extracted = {{16{i_sext & w_half[15]}}, w_half};
         end
         SZ_W: begin
            o_merged    = i_wdata;
            o_extracted = i_rdq;
         end
         default: begin
            o_merged    = i_rdq;
            o_extracted = '0;
         end
      endcase
   end

endmodule

// File: rtl/lsu_dm_master.sv
// Load/store initiator: err 1 cycle, load/word store 2, sub-word store (RMW) 3; one request in flight,
// req_ready only in IDLE. Define LSU_DM_TRACE_EN to print a write trace line in WR.
module lsu_dm_master
   import lsu_dm_master_pkg::*;
#(
   parameter logic [31:0] ADDR_LO = DEF_ADDR_LO,
   parameter logic [31:0] ADDR_HI = DEF_ADDR_HI
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   lsu_dm_req_if.slave   if_req,
   lsu_dm_mem_if.master  if_mem
);

   state_e      r_state, w_next;
   logic        r_we, r_sext, r_err;
   size_e       r_size;
   logic [1:0]  r_lane;
   logic [31:0] r_rdata, r_mem_addr, r_mem_wd, r_mem_pc;

   logic        w_ready, w_mem_we, w_resp_valid;
   logic        w_req_err;
   logic [32:0] w_lo_diff, w_hi_diff;
   logic [31:0] w_merged, w_extracted;
   size_e       w_req_size;

   assign w_req_size = size_e'(if_req.req_size);

   // Borrow bits of 33-bit differences give the window check without constant-compare lint noise.
   assign w_lo_diff = {1'b0, if_req.req_addr} - {1'b0, ADDR_LO};
   assign w_hi_diff = {1'b0, ADDR_HI} - {1'b0, if_req.req_addr};

   assign w_req_err = (w_req_size == SZ_X)
                    || (w_req_size == SZ_H && if_req.req_addr[0])
                    || (w_req_size == SZ_W && if_req.req_addr[1:0] != 2'b00)
                    || w_lo_diff[32]
                    || w_hi_diff[32];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_ready      = 1'b0;
      w_mem_we     = 1'b0;
      w_resp_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready = 1'b1;
            if (if_req.req_valid) begin
               if (w_req_err)                                  w_next = ST_RESP;
               else if (if_req.req_we && w_req_size == SZ_W)   w_next = ST_WR;
               else                                            w_next = ST_RD;
            end
         end
         ST_RD:   w_next = r_we ? ST_WR : ST_RESP;
         ST_WR: begin
            w_mem_we = 1'b1;
            w_next   = ST_RESP;
         end
         ST_RESP: begin
            w_resp_valid = 1'b1;
            w_next       = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Merge/extract works on the live read word so both results can be registered at the end of RD.
   lsu_lane_unit u_lane (
      .i_size      (r_size),
      .i_lane      (r_lane),
      .i_sext      (r_sext),
      .i_wdata     (r_mem_wd),
      .i_rdq       (if_mem.mem_rd),
      .o_merged    (w_merged),
      .o_extracted (w_extracted)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_we       <= 1'b0;
         r_sext     <= 1'b0;
         r_err      <= 1'b0;
         r_size     <= SZ_B;
         r_lane     <= 2'b00;
         r_rdata    <= '0;
         r_mem_addr <= '0;
         r_mem_wd   <= '0;
         r_mem_pc   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (if_req.req_valid) begin
                  r_we    <= if_req.req_we;
                  r_sext  <= if_req.req_sext;
                  r_size  <= w_req_size;
                  r_lane  <= if_req.req_addr[1:0];
                  r_err   <= w_req_err;
                  r_rdata <= '0;
                  // A flagged access leaves the memory-side registers untouched.
                  if (!w_req_err) begin
                     r_mem_addr <= word_addr(if_req.req_addr);
                     r_mem_pc   <= if_req.req_pc;
                     if (if_req.req_we) r_mem_wd <= if_req.req_wdata;
                  end
               end
            end
            ST_RD: begin
               if (r_we) r_mem_wd <= w_merged;
               else      r_rdata  <= w_extracted;
            end
            default: ;
         endcase
      end
   end

`ifdef LSU_DM_TRACE_EN
   always_ff @(posedge i_clk) begin
      if (i_rst_n && r_state == ST_WR)
         $display("%d@%h: *%h <= %h", $time, r_mem_pc, r_mem_addr, r_mem_wd);
   end
`else
   // Silent build: identical datapath, no trace output.
`endif

   assign if_req.req_ready  = w_ready;
   assign if_req.resp_valid = w_resp_valid;
   assign if_req.resp_rdata = r_rdata;
   assign if_req.resp_err   = r_err;
   assign if_mem.mem_we     = w_mem_we;
   assign if_mem.mem_addr   = r_mem_addr;
   assign if_mem.mem_wd     = r_mem_wd;
   assign if_mem.mem_pc     = r_mem_pc;

endmodule

// File: tb/tb_lsu_dm_master.sv
// Bench for lsu_dm_master: directed vector table, reset/busy sequences, randomized run against a byte-level model.
module tb_lsu_dm_master;
   import lsu_dm_master_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic preload = 1'b1;
   always #5 clk = ~clk;

   lsu_dm_req_if req_if ();
   lsu_dm_mem_if mem_if ();

   lsu_dm_master dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .if_req  (req_if),
      .if_mem  (mem_if)
   );

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];
   int          we_cnt = 0;
   logic [31:0] we_pc   = '0;
   logic [31:0] we_addr = '0;

   assign mem_if.mem_rd = (mem_if.mem_addr < 32'h1000) ? mem[mem_if.mem_addr[11:2]] : 32'h0;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
         mem[8] <= 32'hAABB_CCDD;
      end else if (mem_if.mem_we) begin
         we_cnt  <= we_cnt + 1;
         we_pc   <= mem_if.mem_pc;
         we_addr <= mem_if.mem_addr;
         if (mem_if.mem_addr < 32'h1000) mem[mem_if.mem_addr[11:2]] <= mem_if.mem_wd;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Byte-level model: masks and shifts over a word array.
   task automatic ref_access(input logic we, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic err, output logic [31:0] rd, output int lat);
      int nb, sh;
      logic [31:0] m, w, lo, hi;
      lo  = DEF_ADDR_LO;
      hi  = DEF_ADDR_HI;
      err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
            || (a < lo) || (a > hi);
      rd  = 32'h0;
      lat = 1;
      if (!err) begin
         nb = 1 << sz;
         m  = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
         sh = 8 * int'(a % 4);
         w  = ref_mem[a / 4];
         if (we) begin
            ref_mem[a / 4] = (w & ~(m << sh)) | ((wd & m) << sh);
            lat = (nb == 4) ? 2 : 3;
         end else begin
            rd = (w >> sh) & m;
            if (sx && rd[8 * nb - 1]) rd = rd | ~m;
            lat = 2;
         end
      end
   endtask

   task automatic do_req(input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                         output logic err, output logic [31:0] rd, output int lat, output int pulses);
      int t, w0;
      @(negedge clk);
      req_if.req_valid = 1'b1;
      req_if.req_we    = we;
      req_if.req_size  = sz;
      req_if.req_sext  = sx;
      req_if.req_addr  = a;
      req_if.req_wdata = wd;
      req_if.req_pc    = pc;
      t = 0;
      while (!req_if.req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!req_if.req_ready) check("ready_wait", 32'(req_if.req_ready), 32'h1);
      w0 = we_cnt;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         if (lat == 0) req_if.req_valid = 1'b0;
         lat++;
      end while (!req_if.resp_valid && lat < 10);
      err    = req_if.resp_err;
      rd     = req_if.resp_rdata;
      pulses = we_cnt - w0;
   endtask

   task automatic run_one(input string nm, input logic we, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
      logic err;
      logic [31:0] rd, pc;
      int lat, pulses, exp_p;
      pc = $urandom & 32'hFFFF_FFFC;
      do_req(we, sz, sx, a, wd, pc, err, rd, lat, pulses);
      exp_p = (we && !exp_err) ? 1 : 0;
      check({nm, "/err"}, 32'(err), 32'(exp_err));
      check({nm, "/rdata"}, rd, exp_rd);
      check({nm, "/latency"}, lat, exp_lat);
      check({nm, "/we_pulses"}, pulses, exp_p);
      if (exp_p == 1) begin
         check({nm, "/mem_pc"}, we_pc, pc);
         check({nm, "/mem_addr"}, we_addr, a & 32'hFFFF_FFFC);
      end
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        sx;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rd;
      int          exp_lat;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs [18];

   initial begin
      logic        m_err;
      logic [31:0] m_rd;
      int          m_lat, acc, resp, w1;

      vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'h1234_5678, 1'b0, 32'h0,         2, 32'h1234_5678};
      vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,         1'b0, 32'h1234_5678, 2, 32'h0};
      vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h21,   32'h0000_0011, 1'b0, 32'h0,         3, 32'hAABB_11DD};
      vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h23,   32'h0,         1'b0, 32'hFFFF_FFAA, 2, 32'h0};
      vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h23,   32'h0,         1'b0, 32'h0000_00AA, 2, 32'h0};
      vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h20,   32'h0,         1'b0, 32'h0000_11DD, 2, 32'h0};
      vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h20,   32'h0,         1'b0, 32'h0,         2, 32'h0};
      vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h22,   32'hFFFF_BEEF, 1'b0, 32'h0,         3, 32'hBEEF_0000};
      vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h22,   32'h0,         1'b0, 32'hFFFF_BEEF, 2, 32'h0};
      vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h22,   32'h0,         1'b0, 32'h0000_BEEF, 2, 32'h0};
      vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h06,   32'h0,         1'b1, 32'h0,         1, 32'h0};
      vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h13,   32'h5555_5555, 1'b1, 32'h0,         1, 32'h0};
      vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,         1'b1, 32'h0,         1, 32'h0};
      vecs[13] = '{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,         1'b1, 32'h0,         1, 32'h0};
      vecs[14] = '{1'b0, 2'd2, 1'b0, 32'hFFC,  32'h0,         1'b0, 32'h0,         2, 32'h0};
      vecs[15] = '{1'b1, 2'd0, 1'b0, 32'hFFF,  32'h0000_005A, 1'b0, 32'h0,         3, 32'h5A00_0000};
      vecs[16] = '{1'b0, 2'd0, 1'b1, 32'hFFF,  32'h0,         1'b0, 32'h0000_005A, 2, 32'h0};
      vecs[17] = '{1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_0077, 1'b1, 32'h0,         1, 32'h0};

      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
      ref_mem[8] = 32'hAABB_CCDD;

      req_if.req_valid = 1'b0;
      req_if.req_we    = 1'b0;
      req_if.req_size  = 2'd0;
      req_if.req_sext  = 1'b0;
      req_if.req_addr  = 32'h0;
      req_if.req_wdata = 32'h0;
      req_if.req_pc    = 32'h0;

      repeat (3) @(negedge clk);
      check("rst/req_ready",  32'(req_if.req_ready),  32'h1);
      check("rst/resp_valid", 32'(req_if.resp_valid), 32'h0);
      check("rst/resp_err",   32'(req_if.resp_err),   32'h0);
      check("rst/resp_rdata", req_if.resp_rdata,      32'h0);
      check("rst/mem_we",     32'(mem_if.mem_we),     32'h0);
      check("rst/mem_addr",   mem_if.mem_addr,        32'h0);
      check("rst/mem_wd",     mem_if.mem_wd,          32'h0);
      check("rst/mem_pc",     mem_if.mem_pc,          32'h0);
      preload = 1'b0;
      rst_n   = 1'b1;

      for (int i = 0; i < 18; i++) begin
         ref_access(vecs[i].we, vecs[i].sz, vecs[i].sx, vecs[i].addr, vecs[i].wdata, m_err, m_rd, m_lat);
         run_one($sformatf("vec%0d", i), vecs[i].we, vecs[i].sz, vecs[i].sx, vecs[i].addr,
                 vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rd, vecs[i].exp_lat);
         if (vecs[i].we && !vecs[i].exp_err)
            check($sformatf("vec%0d/mem_word", i), mem[vecs[i].addr[11:2]], vecs[i].exp_word);
      end

      // Reset raised during the WR cycle of a word store: no further write strobes or responses.
      @(negedge clk);
      req_if.req_valid = 1'b1;
      req_if.req_we    = 1'b1;
      req_if.req_size  = 2'd2;
      req_if.req_addr  = 32'h100;
      req_if.req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      @(negedge clk);
      req_if.req_valid = 1'b0;
      check("rstwr/mem_we_in_wr", 32'(mem_if.mem_we), 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      w1 = we_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      resp = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (req_if.resp_valid) resp++;
      end
      check("rstwr/we_after_reset", we_cnt - w1, 0);
      check("rstwr/resp_pulses", resp, 0);
      check("rstwr/req_ready", 32'(req_if.req_ready), 32'h1);
      check("rstwr/resp_rdata", req_if.resp_rdata, 32'h0);
      // Memory committed the store at the edge on which reset was sampled.
      ref_mem[32'h100 / 4] = 32'hCAFE_F00D;

      // Request held valid while busy: one accept per transaction, three per nine cycles for loads.
      req_if.req_valid = 1'b1;
      req_if.req_we    = 1'b0;
      req_if.req_size  = 2'd2;
      req_if.req_sext  = 1'b0;
      req_if.req_addr  = 32'h10;
      acc = 0;
      resp = 0;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) @(negedge clk);
         if (req_if.req_valid && req_if.req_ready) acc++;
         if (req_if.resp_valid) begin
            resp++;
            check("busy/rdata", req_if.resp_rdata, ref_mem[4]);
         end
      end
      req_if.req_valid = 1'b0;
      check("busy/accepts", acc, 3);
      check("busy/responses", resp, 3);
      @(negedge clk);

      for (int n = 0; n < 300; n++) begin
         logic        we, sx;
         logic [1:0]  sz;
         logic [31:0] a, wd;
         int          r;
         we = 1'($urandom_range(0, 1));
         sx = 1'($urandom_range(0, 1));
         r  = $urandom_range(0, 9);
         sz = (r == 9) ? 2'd3 : 2'(r % 3);
         if ($urandom_range(0, 15) == 0) a = 32'h1000 + $urandom_range(0, 255);
         else                            a = $urandom_range(0, 511);
         if ($urandom_range(0, 1) == 1 && sz != 2'd3) a = a & ~((32'h1 << sz) - 32'h1);
         wd = $urandom;
         ref_access(we, sz, sx, a, wd, m_err, m_rd, m_lat);
         run_one($sformatf("rnd%0d", n), we, sz, sx, a, wd, m_err, m_rd, m_lat);
         if (we && !m_err)
            check($sformatf("rnd%0d/mem_word", n), mem[a[11:2]], ref_mem[a / 4]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
